// File: rtl/pulse_stretcher.sv
// pulse_stretcher: turns single-cycle request strobes into fixed-width output
// pulses separated by a guaranteed low gap. Requests arriving while busy are
// queued in a saturating pending counter and replayed in order.
// Optional feature macro: PULSE_STRETCH_RETRIGGER_EN. When it is defined, a
// request during the high window extends that window instead of being queued.
module pulse_stretcher #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned GAP_CYCLES  = 2,
    parameter int unsigned CNT_W       = 24,
    parameter int unsigned PEND_W      = 2
) (
    input  logic              CLOCK,
    input  logic              RESET_N,
    input  logic              PULSE_IN,
    input  logic              CLR_OVF,
    output logic              PULSE_OUT,
    output logic              BUSY,
    output logic [PEND_W-1:0] PENDING,
    output logic              OVERFLOW
);

    localparam logic [CNT_W-1:0]  HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [PEND_W-1:0] PEND_MAX  = PEND_W'((1 << PEND_W) - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic retrig_c;
    logic end_high_c;
    logic end_gap_c;
    logic enq_c;
    logic deq_c;
    logic ovf_set_c;

    // Window bookkeeping: retrigger, end of high/gap window, queue push/pop.
    always_comb begin
        retrig_c   = 1'b0;
        end_high_c = 1'b0;
        end_gap_c  = 1'b0;
        enq_c      = 1'b0;
        deq_c      = 1'b0;
        ovf_set_c  = 1'b0;
`ifdef PULSE_STRETCH_RETRIGGER_EN
        retrig_c   = PULSE_IN && (state == S_HIGH);
`else
        retrig_c   = 1'b0;
`endif
        end_high_c = (state == S_HIGH) && (cnt == '0) && !retrig_c;
        // With no gap, the end of the high window doubles as the end of gap.
        if (GAP_CYCLES == 0) begin
            end_gap_c = end_high_c;
        end else begin
            end_gap_c = (state == S_GAP) && (cnt == '0);
        end
        deq_c = end_gap_c && (PENDING != '0);
        // A request at end of gap with an empty queue starts the next window directly.
        enq_c = PULSE_IN && (state != S_IDLE) && !retrig_c
                && !(end_gap_c && (PENDING == '0));
        ovf_set_c = enq_c && !deq_c && (PENDING == PEND_MAX);
    end

    // State machine with registered outputs.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= S_IDLE;
            cnt       <= '0;
            PULSE_OUT <= 1'b0;
            BUSY      <= 1'b0;
        end else if (end_gap_c) begin
            if (deq_c || PULSE_IN) begin
                state     <= S_HIGH;
                cnt       <= HOLD_LOAD;
                PULSE_OUT <= 1'b1;
                BUSY      <= 1'b1;
            end else begin
                state     <= S_IDLE;
                cnt       <= '0;
                PULSE_OUT <= 1'b0;
                BUSY      <= 1'b0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (PULSE_IN) begin
                        state     <= S_HIGH;
                        cnt       <= HOLD_LOAD;
                        PULSE_OUT <= 1'b1;
                        BUSY      <= 1'b1;
                    end
                end
                S_HIGH: begin
                    if (retrig_c) begin
                        cnt <= HOLD_LOAD;
                    end else if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        state     <= S_GAP;
                        cnt       <= GAP_LOAD;
                        PULSE_OUT <= 1'b0;
                    end
                end
                S_GAP: begin
                    cnt <= cnt - CNT_W'(1);
                end
                default: begin
                    state     <= S_IDLE;
                    cnt       <= '0;
                    PULSE_OUT <= 1'b0;
                    BUSY      <= 1'b0;
                end
            endcase
        end
    end

    // Saturating pending counter; a push and a pop in the same cycle cancel.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            PENDING <= '0;
        end else if (enq_c && !deq_c && (PENDING != PEND_MAX)) begin
            PENDING <= PENDING + PEND_W'(1);
        end else if (deq_c && !enq_c) begin
            PENDING <= PENDING - PEND_W'(1);
        end
    end

    // Sticky overflow flag; a new drop wins over a clear in the same cycle.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            OVERFLOW <= 1'b0;
        end else if (ovf_set_c) begin
            OVERFLOW <= 1'b1;
        end else if (CLR_OVF) begin
            OVERFLOW <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Bench for pulse_stretcher: per-cycle vector tables with a scoreboard queue,
// plus a hand-written asynchronous reset sequence. Default parameters.
module tb_pulse_stretcher;

    logic       CLOCK;
    logic       RESET_N;
    logic       PULSE_IN;
    logic       CLR_OVF;
    logic       PULSE_OUT;
    logic       BUSY;
    logic [1:0] PENDING;
    logic       OVERFLOW;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       pin;
        logic       clr;
        logic       o;
        logic       b;
        logic [1:0] p;
        logic       ov;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    pulse_stretcher #(
        .HOLD_CYCLES(4),
        .GAP_CYCLES (2),
        .CNT_W      (24),
        .PEND_W     (2)
    ) dut (
        .CLOCK    (CLOCK),
        .RESET_N  (RESET_N),
        .PULSE_IN (PULSE_IN),
        .CLR_OVF  (CLR_OVF),
        .PULSE_OUT(PULSE_OUT),
        .BUSY     (BUSY),
        .PENDING  (PENDING),
        .OVERFLOW (OVERFLOW)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    task automatic chk(input string what, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0d expected %0d", what, idx, act, exp);
        end
    endtask

    // Append n identical cycles: inputs, then outputs expected after that edge.
    task automatic add(input int n, input bit pin, input bit clr, input bit o,
                       input bit b, input int p, input bit ov);
        vec_t v;
        v.pin = pin;
        v.clr = clr;
        v.o   = o;
        v.b   = b;
        v.p   = 2'(p);
        v.ov  = ov;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    // Drive each vector before an edge, score it just after the edge.
    task automatic run(input string name);
        vec_t e;
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge CLOCK);
            PULSE_IN = vecs[i].pin;
            CLR_OVF  = vecs[i].clr;
            sb.push_back(vecs[i]);
            @(posedge CLOCK);
            #1;
            e = sb.pop_front();
            chk({name, ".pulse_out"}, i, int'(PULSE_OUT), int'(e.o));
            chk({name, ".busy"},      i, int'(BUSY),      int'(e.b));
            chk({name, ".pending"},   i, int'(PENDING),   int'(e.p));
            chk({name, ".overflow"},  i, int'(OVERFLOW),  int'(e.ov));
        end
        vecs.delete();
        @(negedge CLOCK);
        PULSE_IN = 1'b0;
        CLR_OVF  = 1'b0;
    endtask

    task automatic chk_zero(input string name);
        chk({name, ".pulse_out"}, 0, int'(PULSE_OUT), 0);
        chk({name, ".busy"},      0, int'(BUSY),      0);
        chk({name, ".pending"},   0, int'(PENDING),   0);
        chk({name, ".overflow"},  0, int'(OVERFLOW),  0);
    endtask

    initial begin
        RESET_N  = 1'b0;
        PULSE_IN = 1'b0;
        CLR_OVF  = 1'b0;
        #2;
        chk_zero("reset");
        @(negedge CLOCK);
        @(negedge CLOCK);
        RESET_N = 1'b1;

        // Single request: 4 high cycles, 2 gap cycles, then idle.
        add(2, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 1, 1, 0, 0);
        add(3, 0, 0, 1, 1, 0, 0);
        add(2, 0, 0, 0, 1, 0, 0);
        add(2, 0, 0, 0, 0, 0, 0);
        run("single");

        // Three back-to-back requests: three windows, no idle between, 18 busy cycles.
        add(1, 1, 0, 1, 1, 0, 0);
        add(1, 1, 0, 1, 1, 1, 0);
        add(1, 1, 0, 1, 1, 2, 0);
        add(1, 0, 0, 1, 1, 2, 0);
        add(2, 0, 0, 0, 1, 2, 0);
        add(4, 0, 0, 1, 1, 1, 0);
        add(2, 0, 0, 0, 1, 1, 0);
        add(4, 0, 0, 1, 1, 0, 0);
        add(2, 0, 0, 0, 1, 0, 0);
        add(2, 0, 0, 0, 0, 0, 0);
        run("queue3");

        // Six requests: saturate at 3, overflow on the 5th, set beats clear, 4 windows.
        add(1, 1, 0, 1, 1, 0, 0);
        add(1, 1, 0, 1, 1, 1, 0);
        add(1, 1, 0, 1, 1, 2, 0);
        add(1, 1, 0, 1, 1, 3, 0);
        add(1, 1, 0, 0, 1, 3, 1);
        add(1, 1, 1, 0, 1, 3, 1);
        add(1, 0, 0, 1, 1, 2, 1);
        add(3, 0, 0, 1, 1, 2, 1);
        add(2, 0, 0, 0, 1, 2, 1);
        add(4, 0, 0, 1, 1, 1, 1);
        add(2, 0, 0, 0, 1, 1, 1);
        add(4, 0, 0, 1, 1, 0, 1);
        add(2, 0, 0, 0, 1, 0, 1);
        add(2, 0, 0, 0, 0, 0, 1);
        add(1, 0, 1, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0);
        run("saturate");

        // Request on the last gap cycle with empty queue restarts immediately.
        add(1, 1, 0, 1, 1, 0, 0);
        add(3, 0, 0, 1, 1, 0, 0);
        add(2, 0, 0, 0, 1, 0, 0);
        add(1, 1, 0, 1, 1, 0, 0);
        add(3, 0, 0, 1, 1, 0, 0);
        add(2, 0, 0, 0, 1, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0);
        run("gap_edge");

`ifdef PULSE_STRETCH_RETRIGGER_EN
        // Request on the 3rd high cycle extends the window to 7 cycles.
        add(1, 1, 0, 1, 1, 0, 0);
        add(2, 0, 0, 1, 1, 0, 0);
        add(1, 1, 0, 1, 1, 0, 0);
        add(3, 0, 0, 1, 1, 0, 0);
        add(2, 0, 0, 0, 1, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0);
        run("retrig");
`else
        // Request on the last high cycle is queued and replayed after the gap.
        add(1, 1, 0, 1, 1, 0, 0);
        add(2, 0, 0, 1, 1, 0, 0);
        add(1, 1, 0, 1, 1, 1, 0);
        add(2, 0, 0, 0, 1, 1, 0);
        add(4, 0, 0, 1, 1, 0, 0);
        add(2, 0, 0, 0, 1, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0);
        run("late_high");
`endif

        // Saturated queue: push and pop at end of gap leave PENDING at 3, no change in OVERFLOW.
        add(1, 1, 0, 1, 1, 0, 0);
        add(1, 1, 0, 1, 1, 1, 0);
        add(1, 1, 0, 1, 1, 2, 0);
        add(1, 1, 0, 1, 1, 3, 0);
        add(1, 1, 0, 0, 1, 3, 1);
        add(1, 0, 0, 0, 1, 3, 1);
        add(1, 1, 0, 1, 1, 3, 1);
        add(3, 0, 0, 1, 1, 3, 1);
        add(2, 0, 0, 0, 1, 3, 1);
        add(2, 0, 0, 1, 1, 2, 1);
        run("sat_swap");

        // Asynchronous reset mid-window with PENDING=2 clears everything before any edge.
        @(posedge CLOCK);
        #1;
        chk("pre_rst.pending", 0, int'(PENDING), 2);
        chk("pre_rst.pulse_out", 0, int'(PULSE_OUT), 1);
        #2;
        RESET_N = 1'b0;
        #1;
        chk_zero("async_rst");
        @(negedge CLOCK);
        RESET_N = 1'b1;

        // No queued windows replayed after reset release.
        add(14, 0, 0, 0, 0, 0, 0);
        run("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
